// File: rtl/fx68k_rom_pkg.sv
// Shared types and helpers for the fx68k ROM arbiter.
// Tag layout and ROM latency derivation.
package fx68k_rom_pkg;

  typedef struct packed {
    logic valid;
    logic id;
  } rom_tag_t;

  function automatic int rom_latency(input int output_reg);
    return 1 + output_reg;
  endfunction

endpackage

// File: rtl/fx68k_rom_tag_pipe.sv
// Enable-gated tag shift register tracking in-flight ROM reads,
// plus a one-clk fresh flag for the word landing in the last stage.
module fx68k_rom_tag_pipe
  import fx68k_rom_pkg::*;
#(
  parameter int LAT = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clk_ena,
  input  logic i_valid,
  input  logic i_id,
  output logic o_valid,
  output logic o_id,
  output logic o_fresh
);

  rom_tag_t r_stage [LAT];
  rom_tag_t w_in;
  logic     w_fill;
  logic     r_fresh;

  assign w_in = '{valid: i_valid, id: i_id};

  generate
    if (LAT == 1) begin : g_one
      assign w_fill = i_valid;
    end else begin : g_deep
      assign w_fill = r_stage[LAT-2].valid;
    end
  endgenerate

  // fresh only survives one edge so rvalid never stretches over a gap
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < LAT; i++)
        r_stage[i] <= '0;
      r_fresh <= 1'b0;
    end else begin
      r_fresh <= clk_ena & w_fill;
      if (clk_ena) begin
        r_stage[0] <= w_in;
        for (int i = 1; i < LAT; i++)
          r_stage[i] <= r_stage[i-1];
      end
    end
  end

  assign o_valid = r_stage[LAT-1].valid;
  assign o_id    = r_stage[LAT-1].id;
  assign o_fresh = r_fresh;

endmodule

// File: rtl/fx68k_rom_arbiter.sv
// Round-robin sharing of one fx68kRom between the sequencer (port 0)
// and the debug readout (port 1), with tagged response steering.
module fx68k_rom_arbiter
  import fx68k_rom_pkg::*;
#(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 32,
  parameter int OUTPUT_REG = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clk_ena,
  input  logic                  req0,
  input  logic [ADDR_WIDTH-1:0] addr0,
  output logic                  gnt0,
  output logic                  rvalid0,
  input  logic                  req1,
  input  logic [ADDR_WIDTH-1:0] addr1,
  output logic                  gnt1,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic [ADDR_WIDTH-1:0] rom_addr,
  input  logic [DATA_WIDTH-1:0] rom_q
);

  localparam int LAT = rom_latency(OUTPUT_REG);

  logic                  r_last_gnt;
  logic [ADDR_WIDTH-1:0] r_hold;
  logic                  w_sel;
  logic                  w_issue;
  logic [ADDR_WIDTH-1:0] w_rom_addr;
  logic                  w_tail_valid;
  logic                  w_tail_id;
  logic                  w_fresh;

  // on contention the port that did not win last time goes first
  assign w_sel   = (req0 & req1) ? ~r_last_gnt : req1;
  assign w_issue = rst_n & clk_ena & (req0 | req1);

  assign gnt0 = w_issue & ~w_sel;
  assign gnt1 = w_issue & w_sel;

  assign w_rom_addr = w_issue ? (w_sel ? addr1 : addr0) : r_hold;
  assign rom_addr   = w_rom_addr;

  // hold keeps the ROM address register stable between issues
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_gnt <= 1'b1;
      r_hold     <= '0;
    end else begin
      r_hold <= w_rom_addr;
      if (w_issue)
        r_last_gnt <= w_sel;
    end
  end

  fx68k_rom_tag_pipe #(
    .LAT (LAT)
  ) u_tag_pipe (
    .clk     (clk),
    .rst_n   (rst_n),
    .clk_ena (clk_ena),
    .i_valid (w_issue),
    .i_id    (w_sel),
    .o_valid (w_tail_valid),
    .o_id    (w_tail_id),
    .o_fresh (w_fresh)
  );

  assign rvalid0 = w_tail_valid & ~w_tail_id & w_fresh;
  assign rvalid1 = w_tail_valid & w_tail_id & w_fresh;
  assign rdata   = rom_q;

endmodule

// File: tb/tb_fx68k_rom_arbiter.sv
// Self-checking bench: vector table plus scoreboard for responses,
// hand sequences for clk_ena gaps, mid-flight reset and OUTPUT_REG=0.
module tb_fx68k_rom_arbiter;

  localparam int LAT_A = 2;

  logic        clk;
  logic        rst_n;
  logic        clk_ena;
  logic        req0, req1;
  logic [9:0]  addr0, addr1;
  logic        gnt0, gnt1, rvalid0, rvalid1;
  logic [31:0] rdata, rom_q;
  logic [9:0]  rom_addr;

  logic        b_en;
  logic        b_req0, b_req1;
  logic [9:0]  b_addr0, b_addr1;
  logic        b_gnt0, b_gnt1, b_rvalid0, b_rvalid1;
  logic [31:0] b_rdata, b_rom_q;
  logic [9:0]  b_rom_addr;

  int n_err = 0;
  int n_chk = 0;
  string cur = "init";

  function automatic logic [31:0] rom_f(input logic [9:0] a);
    return {a, 6'h2A, ~a, 6'h15};
  endfunction

  fx68k_rom_arbiter #(
    .ADDR_WIDTH (10), .DATA_WIDTH (32), .OUTPUT_REG (1)
  ) dut (
    .clk (clk), .rst_n (rst_n), .clk_ena (clk_ena),
    .req0 (req0), .addr0 (addr0), .gnt0 (gnt0), .rvalid0 (rvalid0),
    .req1 (req1), .addr1 (addr1), .gnt1 (gnt1), .rvalid1 (rvalid1),
    .rdata (rdata), .rom_addr (rom_addr), .rom_q (rom_q)
  );

  fx68k_rom_arbiter #(
    .ADDR_WIDTH (10), .DATA_WIDTH (32), .OUTPUT_REG (0)
  ) dut_b (
    .clk (clk), .rst_n (rst_n), .clk_ena (b_en),
    .req0 (b_req0), .addr0 (b_addr0), .gnt0 (b_gnt0), .rvalid0 (b_rvalid0),
    .req1 (b_req1), .addr1 (b_addr1), .gnt1 (b_gnt1), .rvalid1 (b_rvalid1),
    .rdata (b_rdata), .rom_addr (b_rom_addr), .rom_q (b_rom_q)
  );

  // ROM models: free-running address register, gated output register
  logic [9:0]  ra_addr, rb_addr;
  logic [31:0] ra_q;
  always @(posedge clk) begin
    ra_addr <= rom_addr;
    if (clk_ena) ra_q <= rom_f(ra_addr);
    rb_addr <= b_rom_addr;
  end
  assign rom_q   = ra_q;
  assign b_rom_q = rom_f(rb_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit         rs;
    bit         en;
    bit         r0;
    logic [9:0] a0;
    bit         r1;
    logic [9:0] a1;
    bit         g0;
    bit         g1;
  } vec_t;

  typedef struct {
    logic        id;
    logic [31:0] data;
    int          left;
  } sb_t;

  sb_t         sb[$];
  logic        exp_rv;
  logic        exp_id;
  logic [31:0] exp_data;
  logic [9:0]  m_hold;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s/%s: got %h expected %h", cur, nm, act, exp);
    end
  endtask

  function automatic vec_t mk(bit rs, bit en, bit r0, logic [9:0] a0,
                              bit r1, logic [9:0] a1, bit g0, bit g1);
    vec_t v;
    v.rs = rs; v.en = en; v.r0 = r0; v.a0 = a0;
    v.r1 = r1; v.a1 = a1; v.g0 = g0; v.g1 = g1;
    return v;
  endfunction

  task automatic apply_reset();
    rst_n = 1'b0;
    req0 = 0; req1 = 0; addr0 = 0; addr1 = 0; clk_ena = 1;
    sb.delete();
    exp_rv = 0; exp_id = 0; exp_data = 0; m_hold = 0;
    #1;
    chk("rst_gnt0", gnt0, 0);
    chk("rst_gnt1", gnt1, 0);
    chk("rst_rv0", rvalid0, 0);
    chk("rst_rv1", rvalid1, 0);
    chk("rst_addr", rom_addr, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic step(input vec_t v);
    logic       iss;
    logic [9:0] wa;
    sb_t        e;
    @(negedge clk);
    clk_ena = v.en; req0 = v.r0; addr0 = v.a0;
    req1 = v.r1; addr1 = v.a1;
    #1;
    iss = v.g0 | v.g1;
    wa  = v.g1 ? v.a1 : v.a0;
    chk("gnt0", gnt0, v.g0);
    chk("gnt1", gnt1, v.g1);
    chk("rom_addr", rom_addr, iss ? wa : m_hold);
    chk("rvalid0", rvalid0, exp_rv & ~exp_id);
    chk("rvalid1", rvalid1, exp_rv & exp_id);
    if (exp_rv) chk("rdata", rdata, exp_data);
    @(posedge clk);
    if (iss) m_hold = wa;
    exp_rv = 0;
    if (v.en) begin
      if (iss) begin
        e.id = v.g1; e.data = rom_f(wa); e.left = LAT_A;
        sb.push_back(e);
      end
      foreach (sb[i]) sb[i].left = sb[i].left - 1;
      if (sb.size() > 0 && sb[0].left == 0) begin
        e = sb.pop_front();
        exp_rv = 1; exp_id = e.id; exp_data = e.data;
      end
    end
  endtask

  vec_t tbl[$];
  logic [31:0] bq[$];

  initial begin
    rst_n = 0; clk_ena = 1; req0 = 0; req1 = 0; addr0 = 0; addr1 = 0;
    b_en = 1; b_req0 = 0; b_req1 = 0; b_addr0 = 0; b_addr1 = 0;

    // single port: grant in cycle 2, rvalid0 in cycle 4
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 10'h155, 0, 0, 1, 0));
    repeat (4) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // continuous contention alternates starting at port 0
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    for (int k = 0; k < 6; k++)
      tbl.push_back(mk(0, 1, 1, 10'h010, 1, 10'h020, k % 2 == 0, k % 2 == 1));
    repeat (3) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    // withdrawn req1 leaves last_gnt=0, so port 1 wins next
    tbl.push_back(mk(1, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 10'h040, 1, 10'h050, 1, 0));
    tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 10'h060, 1, 10'h070, 0, 1));
    tbl.push_back(mk(0, 1, 1, 10'h060, 0, 0, 1, 0));
    repeat (3) tbl.push_back(mk(0, 1, 0, 0, 0, 0, 0, 0));

    cur = "table";
    foreach (tbl[i]) begin
      if (tbl[i].rs) apply_reset();
      step(tbl[i]);
    end

    cur = "gate";
    apply_reset();
    step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 1, 10'h3FF, 0, 1));
    repeat (3) step(mk(0, 0, 1, 10'h123, 1, 10'h022, 0, 0));
    step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    step(mk(0, 0, 0, 0, 0, 0, 0, 0));
    chk("rdata_hold", rdata, rom_f(10'h3FF));
    repeat (2) step(mk(0, 1, 0, 0, 0, 0, 0, 0));

    cur = "rstmid";
    apply_reset();
    step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 0, 0, 1, 10'h0AA, 0, 1));
    @(negedge clk);
    req1 = 1; addr1 = 10'h0BB; clk_ena = 1;
    #2 rst_n = 0;
    #1;
    chk("mid_gnt1", gnt1, 0);
    chk("mid_rv1", rvalid1, 0);
    chk("mid_addr", rom_addr, 0);
    apply_reset();
    repeat (4) step(mk(0, 1, 0, 0, 0, 0, 0, 0));
    step(mk(0, 1, 1, 10'h111, 1, 10'h222, 1, 0));
    repeat (3) step(mk(0, 1, 0, 0, 0, 0, 0, 0));

    cur = "olat0";
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      b_req0 = (k < 3);
      b_addr0 = 10'(k + 1);
      #1;
      chk("b_gnt0", b_gnt0, k < 3);
      chk("b_gnt1", b_gnt1, 0);
      chk("b_rvalid1", b_rvalid1, 0);
      chk("b_rvalid0", b_rvalid0, bq.size() > 0);
      if (bq.size() > 0) chk("b_rdata", b_rdata, bq.pop_front());
      if (k < 3) bq.push_back(rom_f(10'(k + 1)));
    end
    b_req0 = 0;

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule

// File: doc/fx68k_rom_arbiter.md
Name: fx68k_rom_arbiter

Overview:
- Shares one synchronous microcode/nanocode ROM instance (`fx68kRom`) between two read requesters: port 0 is the core sequencer and port 1 is the debug/test readout.
- Arbitrates round-robin, drives the ROM address, and tracks in-flight reads through a tag pipeline that matches the ROM read latency.
- Steers each result back to its requester with a one-cycle valid pulse.
- Sits directly in front of `fx68kRom` and honours the same `clk_ena` qualification as the ROM output register.

Parameters:
- ADDR_WIDTH, 10, ROM address width; must equal the ROM's ADDR_WIDTH.
- DATA_WIDTH, 32, ROM word width.
- OUTPUT_REG, 1, matches the ROM's OUTPUT_REG; read latency LAT = 1 + OUTPUT_REG enabled cycles.

Ports:
- clk  in  1  system clock; also clocks the ROM.
- rst_n  in  1  asynchronous, active-low reset.
- clk_ena  in  1  cycle enable, same signal fed to the ROM clk_ena.
- req0  in  1  port 0 read request; held with addr0 until gnt0.
- addr0  in  ADDR_WIDTH  port 0 read address.
- gnt0  out  1  port 0 request accepted this cycle (combinational).
- rvalid0  out  1  port 0 read data valid (one-clk pulse).
- req1, addr1, gnt1, rvalid1: same definitions for port 1.
- rdata  out  DATA_WIDTH  read data, broadcast to both ports; equals rom_q.
- rom_addr  out  ADDR_WIDTH  to ROM addr.
- rom_q  in  DATA_WIDTH  from ROM q.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - gnt0, gnt1, rvalid0 and rvalid1 are 0.
  - The address hold register is 0, so rom_addr is 0.
  - Tag pipeline is all invalid.
  - last_gnt is 1, so port 0 wins the first contention.
  - The fresh flag is 0.
- Issue happens only in cycles with clk_ena=1. At most one grant per cycle. gntN = reqN AND clk_ena AND (arbiter selects N).
- Arbitration:
  - Only one req: that port wins.
  - Both req: the port not equal to last_gnt wins.
  - last_gnt updates to the winner on every issue.
  - No starvation: under continuous contention, grants strictly alternate.
- rom_addr:
  - Issue cycle: addr of the winner, combinationally.
  - Otherwise: the hold register. The hold register captures rom_addr every clk.
  - Consequence: the ROM's free-running address register re-captures the same address, and the unregistered ROM output stays stable while clk_ena=0.
- Tag pipeline: LAT stages, each holding {valid, id}.
  - Stage 0 loads {issue, winner} at the clk edge ending the issue cycle.
  - All stages shift only on edges where clk_ena=1 and hold otherwise.
  - Stage 0 loads 0 on enabled non-issue edges.
- Response:
  - The last stage valid with id N means rom_q holds the word for the read issued LAT enabled edges earlier.
  - rvalidN = last-stage valid AND id==N AND fresh.
  - fresh is set on each edge that loads a valid into the last stage, and cleared on the next clk edge.
  - Result: rvalid is exactly one clk wide even when clk_ena stays low afterwards. rdata stays stable until the next enabled edge.
- Throughput: one read per enabled cycle, back-to-back; no bubbles between ports.
- Requester protocol:
  - reqN may deassert only after gntN.
  - If req drops without a grant, the request is simply withdrawn; no state is kept.
- Reset mid-operation: all in-flight reads are discarded, and no rvalid is produced for them after reset release.
- Overflow is impossible (no queues); a requester is backpressured only by losing arbitration or by clk_ena=0.

Decomposition:
- Package fx68k_rom_pkg holds:
  - typedef rom_tag_t {logic valid; logic id;}
  - localparam function rom_latency(OUTPUT_REG) returning 1+OUTPUT_REG.
- One sub-module is natural: fx68k_rom_tag_pipe, a LAT-deep enable-gated shift register of rom_tag_t with the fresh-flag generator.
- Arbitration and the address mux stay in the top level.

Test Plan:
- Single port, OUTPUT_REG=1, clk_ena=1:
  - Stimulus: req0 with addr0=0x155 at cycle 2.
  - Required: gnt0=1 in cycle 2, rom_addr=0x155 in cycle 2, rvalid0=1 exactly in cycle 4 with rdata=ROM[0x155], rvalid1 never asserts.
- Contention:
  - Stimulus: req0 and req1 held high for 6 cycles, addr0=0x010 and addr1=0x020.
  - Required: grants in the order 0,1,0,1,0,1 and rvalids in the same order LAT cycles later, with matching data.
- clk_ena gating:
  - Stimulus: issue on port 1 (addr 0x3FF), then clk_ena=0 for 3 cycles.
  - Required: no gnt while clk_ena=0, rom_addr held at 0x3FF, rvalid1 a single-cycle pulse after the second enabled edge, rdata stable through the gap.
- OUTPUT_REG=0: back-to-back port 0 reads of 0x001, 0x002, 0x003 -> rvalid0 high in 3 consecutive cycles, each one cycle after its grant, with the corresponding data.
- Reset mid-flight: assert rst_n=0 one cycle after a grant -> outputs clear immediately, no rvalid after release, and the first post-reset contention goes to port 0.
- Withdrawn request: req1 pulses for one cycle while port 0 wins -> no gnt1, no rvalid1, and last_gnt=0 so port 1 wins the next contention.
